pattern_scheduler: RTL and testbench

//  Sequences the 8-entry pattern buffer bank: drives buffer_select/bufp through a

---
 rtl/pattern_scheduler.sv | 229 ++++++++++++++++++++++
 tb/tb_pattern_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scheduler.sv
// pattern_scheduler: walks buffer_select/bufp through a programmable range of the
// 8-entry pattern buffer bank. Each buffer gets (repeat_count + 1) passes. The block
// also arbitrates host serial-load access so that the buffer being played, and the
// buffer queued next, are never overwritten.
// Optional feature: define PATSCHED_UNDERRUN_EN to implement the sticky underrun
// flag, which is then cleared by an accepted start. When the macro is undefined,
// underrun is tied low. Stall behaviour is the same in both builds.
module pattern_scheduler #(
    parameter int NO_BUFS    = 8,
    parameter int BUF_ADDR_W = 3,
    parameter int REPEAT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  step,
    input  logic [BUF_ADDR_W-1:0] first_buf,
    input  logic [BUF_ADDR_W-1:0] last_buf,
    input  logic [REPEAT_W-1:0]   repeat_count,
    input  logic                  load_req,
    input  logic [BUF_ADDR_W-1:0] load_addr,
    input  logic                  load_done,
    output logic [BUF_ADDR_W-1:0] buffer_select,
    output logic [BUF_ADDR_W-1:0] bufp,
    output logic                  running,
    output logic                  wrap,
    output logic                  load_gnt,
    output logic                  ssel,
    output logic [BUF_ADDR_W-1:0] saddr,
    output logic                  underrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [BUF_ADDR_W-1:0] r_cur;
    logic [BUF_ADDR_W-1:0] r_first;
    logic [BUF_ADDR_W-1:0] r_last;
    logic [BUF_ADDR_W-1:0] r_saddr;
    logic [REPEAT_W-1:0]   r_rep;
    logic                  r_running;
    logic                  r_wrap;
    logic                  r_gnt;

    logic [BUF_ADDR_W-1:0] w_cur_nxt;
    logic [BUF_ADDR_W-1:0] w_first_nxt;
    logic [BUF_ADDR_W-1:0] w_last_nxt;
    logic [BUF_ADDR_W-1:0] w_adv_buf;
    logic [BUF_ADDR_W-1:0] w_look_buf;
    logic [BUF_ADDR_W-1:0] w_saddr_nxt;
    logic [REPEAT_W-1:0]   w_rep_nxt;
    logic                  w_wrap_nxt;
    logic                  w_gnt_nxt;
    logic                  w_block;
    logic                  w_start_acc;
    logic                  w_addr_free;

    // Successor of a buffer within the range [first, last]. When first > last, the
    // range passes through the top index and continues from 0.
    function automatic logic [BUF_ADDR_W-1:0] f_succ(
        input logic [BUF_ADDR_W-1:0] cur,
        input logic [BUF_ADDR_W-1:0] first,
        input logic [BUF_ADDR_W-1:0] last
    );
        logic [BUF_ADDR_W-1:0] res;
        if (cur == last) begin
            res = first;
        end else if (cur == BUF_ADDR_W'(NO_BUFS - 1)) begin
            res = {BUF_ADDR_W{1'b0}};
        end else begin
            res = cur + 1'b1;
        end
        return res;
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic. In IDLE, start takes priority and a simultaneous stop is dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_RUN;
                else       w_state_nxt = ST_IDLE;
            end
            ST_RUN: begin
                if (stop) w_state_nxt = ST_DRAIN;
                else      w_state_nxt = ST_RUN;
            end
            ST_DRAIN: begin
                if (step) w_state_nxt = ST_IDLE;
                else      w_state_nxt = ST_DRAIN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output logic: sequencer datapath update (range latch, repeats, advance/stall)
    always_comb begin
        w_cur_nxt   = r_cur;
        w_rep_nxt   = r_rep;
        w_first_nxt = r_first;
        w_last_nxt  = r_last;
        w_wrap_nxt  = 1'b0;
        w_block     = 1'b0;
        w_start_acc = 1'b0;
        w_adv_buf   = f_succ(r_cur, r_first, r_last);
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_first_nxt = first_buf;
                    w_last_nxt  = last_buf;
                    w_cur_nxt   = first_buf;
                    w_rep_nxt   = {REPEAT_W{1'b0}};
                end else begin
                    w_start_acc = 1'b0;
                end
            end
            ST_RUN: begin
                if (!step) begin
                    w_rep_nxt = r_rep;
                end else if (r_rep < repeat_count) begin
                    w_rep_nxt = r_rep + 1'b1;
                end else if (r_gnt && (w_adv_buf == r_saddr)) begin
                    // The host is still loading the next buffer: hold and retry on the next step.
                    w_block   = 1'b1;
                    w_rep_nxt = {REPEAT_W{1'b0}};
                end else begin
                    w_cur_nxt  = w_adv_buf;
                    w_rep_nxt  = {REPEAT_W{1'b0}};
                    w_wrap_nxt = (r_cur == r_last);
                end
            end
            ST_DRAIN: begin
                w_cur_nxt = r_cur;
            end
            default: begin
                w_cur_nxt = r_cur;
            end
        endcase
    end

    // Load arbitration, evaluated against post-step current/next so the sequencer wins ties
    always_comb begin
        w_look_buf  = f_succ(w_cur_nxt, w_first_nxt, w_last_nxt);
        w_addr_free = (load_addr != w_cur_nxt) && (load_addr != w_look_buf);
        w_gnt_nxt   = r_gnt;
        w_saddr_nxt = r_saddr;
        if (r_gnt) begin
            if (load_done) w_gnt_nxt = 1'b0;
            else           w_gnt_nxt = 1'b1;
        end else if (load_req && ((w_state_nxt == ST_IDLE) || w_addr_free)) begin
            w_gnt_nxt   = 1'b1;
            w_saddr_nxt = load_addr;
        end else begin
            w_gnt_nxt = 1'b0;
        end
    end

    // Sequencer and arbitration registers; reset also drops any grant immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur     <= {BUF_ADDR_W{1'b0}};
            r_first   <= {BUF_ADDR_W{1'b0}};
            r_last    <= {BUF_ADDR_W{1'b0}};
            r_rep     <= {REPEAT_W{1'b0}};
            r_saddr   <= {BUF_ADDR_W{1'b0}};
            r_gnt     <= 1'b0;
            r_wrap    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_cur     <= w_cur_nxt;
            r_first   <= w_first_nxt;
            r_last    <= w_last_nxt;
            r_rep     <= w_rep_nxt;
            r_saddr   <= w_saddr_nxt;
            r_gnt     <= w_gnt_nxt;
            r_wrap    <= w_wrap_nxt;
            r_running <= (w_state_nxt != ST_IDLE);
        end
    end

`ifdef PATSCHED_UNDERRUN_EN
    logic r_underrun;

    // Sticky underrun flag: set by a stalled advance, cleared by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun <= 1'b0;
        end else if (w_start_acc) begin
            r_underrun <= 1'b0;
        end else if (w_block) begin
            r_underrun <= 1'b1;
        end else begin
            r_underrun <= r_underrun;
        end
    end

    assign underrun = r_underrun;
`else
    logic w_unused_flag;
    assign w_unused_flag = w_block ^ w_start_acc;
    assign underrun      = 1'b0;
`endif

    assign buffer_select = r_cur;
    assign bufp          = r_cur;
    assign running       = r_running;
    assign wrap          = r_wrap;
    assign load_gnt      = r_gnt;
    assign ssel          = r_gnt;
    assign saddr         = r_saddr;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Testbench for pattern_scheduler: table of per-cycle vectors with a scoreboard queue,
// plus hand-written reset sequences (power-on, async reset mid-grant/mid-run).
module tb_pattern_scheduler;

`ifdef PATSCHED_UNDERRUN_EN
    localparam logic UND_EN = 1'b1;
`else
    localparam logic UND_EN = 1'b0;
`endif
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start, stop, step, load_req, load_done;
    logic [2:0] first_buf, last_buf, load_addr;
    logic [7:0] repeat_count;
    logic [2:0] buffer_select, bufp, saddr;
    logic       running, wrap, load_gnt, ssel, underrun;

    pattern_scheduler #(.NO_BUFS(8), .BUF_ADDR_W(3), .REPEAT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step),
        .first_buf(first_buf), .last_buf(last_buf), .repeat_count(repeat_count),
        .load_req(load_req), .load_addr(load_addr), .load_done(load_done),
        .buffer_select(buffer_select), .bufp(bufp), .running(running), .wrap(wrap),
        .load_gnt(load_gnt), .ssel(ssel), .saddr(saddr), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic st, sp, sk;
        logic [2:0] f, l;
        logic [7:0] rc;
        logic lr;
        logic [2:0] la;
        logic ld;
        logic [2:0] esel;
        logic erun, ewrap, egnt;
        logic [2:0] esaddr;
        logic eund;
    } vec_t;

    vec_t       vecs[$];
    logic [13:0] exp_q[$];
    int          id_q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    function automatic vec_t mk(input logic st, sp, sk, input logic [2:0] f, l,
                                input logic [7:0] rc, input logic lr, input logic [2:0] la,
                                input logic ld, input logic [2:0] esel, input logic erun,
                                ewrap, egnt, input logic [2:0] esaddr, input logic eund);
        vec_t v;
        v.st = st; v.sp = sp; v.sk = sk; v.f = f; v.l = l; v.rc = rc;
        v.lr = lr; v.la = la; v.ld = ld; v.esel = esel; v.erun = erun;
        v.ewrap = ewrap; v.egnt = egnt; v.esaddr = esaddr; v.eund = eund;
        return v;
    endfunction

    // Expected output image: {sel, bufp, running, wrap, gnt, ssel, saddr, underrun}
    function automatic logic [13:0] pack_exp(input vec_t v);
        return {v.esel, v.esel, v.erun, v.ewrap, v.egnt, v.egnt, v.esaddr, v.eund & UND_EN};
    endfunction

    task automatic check_out(input string tag);
        logic [13:0] act, exp;
        int id;
        act = {buffer_select, bufp, running, wrap, load_gnt, ssel, saddr, underrun};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, got %b", tag, act);
        end else begin
            exp = exp_q.pop_front();
            id  = id_q.pop_front();
            if (act !== exp) begin
                n_bad++;
                $display("FAIL %s#%0d: got sel,bufp,run,wrap,gnt,ssel,saddr,und=%b expected %b",
                         tag, id, act, exp);
            end
        end
    endtask

    task automatic drive_idle();
        start = 1'b0; stop = 1'b0; step = 1'b0; load_req = 1'b0; load_done = 1'b0;
        first_buf = 3'd0; last_buf = 3'd0; load_addr = 3'd0; repeat_count = 8'd0;
    endtask

    task automatic apply(input vec_t v, input int id, input string tag);
        start = v.st; stop = v.sp; step = v.sk; first_buf = v.f; last_buf = v.l;
        repeat_count = v.rc; load_req = v.lr; load_addr = v.la; load_done = v.ld;
        exp_q.push_back(pack_exp(v));
        id_q.push_back(id);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic expect_zero(input string tag);
        exp_q.push_back(14'd0);
        id_q.push_back(0);
        check_out(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        // Range 2..4, one pass each: wrap after steps 3 and 6; then drain/idle corners
        vecs.push_back(mk(H,L,L,3'd2,3'd4,8'd0,L,3'd0,L, 3'd2,H,L,L,3'd0,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd0,L,3'd0,L, 3'd3,H,L,L,3'd0,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd0,L,3'd0,L, 3'd4,H,L,L,3'd0,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd0,L,3'd0,L, 3'd2,H,H,L,3'd0,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd0,L,3'd0,L, 3'd3,H,L,L,3'd0,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd0,L,3'd0,L, 3'd4,H,L,L,3'd0,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd0,L,3'd0,L, 3'd2,H,H,L,3'd0,L));
        vecs.push_back(mk(L,L,L,3'd0,3'd0,8'd0,L,3'd0,L, 3'd2,H,L,L,3'd0,L));
        vecs.push_back(mk(L,H,L,3'd0,3'd0,8'd0,L,3'd0,L, 3'd2,H,L,L,3'd0,L));
        vecs.push_back(mk(L,L,L,3'd0,3'd0,8'd0,L,3'd0,L, 3'd2,H,L,L,3'd0,L));
        vecs.push_back(mk(L,H,L,3'd0,3'd0,8'd0,L,3'd0,L, 3'd2,H,L,L,3'd0,L));
        vecs.push_back(mk(H,L,L,3'd7,3'd7,8'd0,L,3'd0,L, 3'd2,H,L,L,3'd0,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd0,L,3'd0,L, 3'd2,L,L,L,3'd0,L));
        vecs.push_back(mk(L,H,L,3'd0,3'd0,8'd0,L,3'd0,L, 3'd2,L,L,L,3'd0,L));
        // Range 6..1 (through 7->0), one extra pass per buffer
        vecs.push_back(mk(H,L,L,3'd6,3'd1,8'd1,L,3'd0,L, 3'd6,H,L,L,3'd0,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd1,L,3'd0,L, 3'd6,H,L,L,3'd0,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd1,L,3'd0,L, 3'd7,H,L,L,3'd0,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd1,L,3'd0,L, 3'd7,H,L,L,3'd0,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd1,L,3'd0,L, 3'd0,H,L,L,3'd0,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd1,L,3'd0,L, 3'd0,H,L,L,3'd0,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd1,L,3'd0,L, 3'd1,H,L,L,3'd0,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd1,L,3'd0,L, 3'd1,H,L,L,3'd0,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd1,L,3'd0,L, 3'd6,H,H,L,3'd0,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd1,L,3'd0,L, 3'd6,H,L,L,3'd0,L));
        vecs.push_back(mk(L,H,L,3'd0,3'd0,8'd1,L,3'd0,L, 3'd6,H,L,L,3'd0,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd1,L,3'd0,L, 3'd6,L,L,L,3'd0,L));
        // Range 2..6: load arbitration, step priority, stall on the loading buffer
        vecs.push_back(mk(H,L,L,3'd2,3'd6,8'd0,L,3'd0,L, 3'd2,H,L,L,3'd0,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd0,H,3'd4,L, 3'd3,H,L,L,3'd0,L));
        vecs.push_back(mk(L,L,L,3'd0,3'd0,8'd0,H,3'd4,L, 3'd3,H,L,L,3'd0,L));
        vecs.push_back(mk(L,L,L,3'd0,3'd0,8'd0,H,3'd6,L, 3'd3,H,L,H,3'd6,L));
        vecs.push_back(mk(L,L,L,3'd0,3'd0,8'd0,L,3'd0,L, 3'd3,H,L,H,3'd6,L));
        vecs.push_back(mk(L,L,L,3'd0,3'd0,8'd0,L,3'd0,H, 3'd3,H,L,L,3'd6,L));
        vecs.push_back(mk(L,L,L,3'd0,3'd0,8'd0,L,3'd0,H, 3'd3,H,L,L,3'd6,L));
        vecs.push_back(mk(L,L,L,3'd0,3'd0,8'd0,H,3'd5,L, 3'd3,H,L,H,3'd5,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd0,L,3'd0,L, 3'd4,H,L,H,3'd5,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd0,L,3'd0,L, 3'd4,H,L,H,3'd5,H));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd0,L,3'd0,L, 3'd4,H,L,H,3'd5,H));
        vecs.push_back(mk(L,L,L,3'd0,3'd0,8'd0,L,3'd0,H, 3'd4,H,L,L,3'd5,H));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd0,L,3'd0,L, 3'd5,H,L,L,3'd5,H));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd0,L,3'd0,L, 3'd6,H,L,L,3'd5,H));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd0,L,3'd0,L, 3'd2,H,H,L,3'd5,H));
        vecs.push_back(mk(L,H,L,3'd0,3'd0,8'd0,L,3'd0,L, 3'd2,H,L,L,3'd5,H));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd0,L,3'd0,L, 3'd2,L,L,L,3'd5,H));
        // start+stop together: start wins, underrun cleared
        vecs.push_back(mk(H,H,L,3'd2,3'd4,8'd0,L,3'd0,L, 3'd2,H,L,L,3'd5,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd0,L,3'd0,L, 3'd3,H,L,L,3'd5,L));
        vecs.push_back(mk(L,L,L,3'd0,3'd0,8'd0,H,3'd3,L, 3'd3,H,L,L,3'd5,L));
        vecs.push_back(mk(L,H,L,3'd0,3'd0,8'd0,L,3'd0,L, 3'd3,H,L,L,3'd5,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd0,L,3'd0,L, 3'd3,L,L,L,3'd5,L));
        // IDLE grants any address; single-buffer range then stalls on it
        vecs.push_back(mk(L,L,L,3'd0,3'd0,8'd0,H,3'd3,L, 3'd3,L,L,H,3'd3,L));
        vecs.push_back(mk(H,L,L,3'd3,3'd3,8'd0,L,3'd0,L, 3'd3,H,L,H,3'd3,L));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd0,L,3'd0,L, 3'd3,H,L,H,3'd3,H));
        vecs.push_back(mk(L,L,L,3'd0,3'd0,8'd0,L,3'd0,H, 3'd3,H,L,L,3'd3,H));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd0,L,3'd0,L, 3'd3,H,H,L,3'd3,H));
        vecs.push_back(mk(L,L,H,3'd0,3'd0,8'd0,L,3'd0,L, 3'd3,H,H,L,3'd3,H));
        vecs.push_back(mk(L,L,L,3'd0,3'd0,8'd0,L,3'd0,L, 3'd3,H,L,L,3'd3,H));
        vecs.push_back(mk(L,L,L,3'd0,3'd0,8'd0,H,3'd7,L, 3'd3,H,L,H,3'd7,H));

        // Power-on reset
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_zero("reset");

        foreach (vecs[i]) apply(vecs[i], i, "vec");

        // Async reset while running with a grant held: outputs clear before any edge
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        expect_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_zero("post_rst");

        // Recovery after reset: fresh start, step with a same-cycle request, wrap
        apply(mk(H,L,L,3'd1,3'd2,8'd0,L,3'd0,L, 3'd1,H,L,L,3'd0,L), 0, "recover");
        apply(mk(L,L,H,3'd0,3'd0,8'd0,H,3'd5,L, 3'd2,H,L,H,3'd5,L), 1, "recover");
        apply(mk(L,L,H,3'd0,3'd0,8'd0,L,3'd0,L, 3'd1,H,H,H,3'd5,L), 2, "recover");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
